// File: rtl/pll_reset_ctrl.sv
// pll_reset_ctrl: reset sequencer and lock supervisor for the fabric PLL.
// It pulses the PLL reset, waits a bounded time for lock and retries a fixed
// number of times. Once lock has been stable for long enough it releases the
// downstream reset. A loss of lock while running starts the sequence again.
// Everything runs on the free-running reference clock.
//
// Handshakes: there is no valid/ready traffic here. soft_reset is a
// single-cycle request that takes effect on the next edge. pll_locked is
// asynchronous and is only used after the 2-FF synchronizer (locked_s).
module pll_reset_ctrl #(
  parameter int RST_HOLD_CYCLES    = 16,
  parameter int LOCK_TIMEOUT       = 50000,
  parameter int LOCK_STABLE_CYCLES = 256,
  parameter int MAX_RETRIES        = 3,
  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
  input  logic          refclk,
  input  logic          rst_n,
  input  logic          pll_locked,
  input  logic          soft_reset,
  output logic          pll_rst,
  output logic          sys_rst_n,
  output logic          ready,
  output logic          fail,
  output logic [RW-1:0] retry_cnt,
  output logic [7:0]    lock_loss_cnt,
  output logic [2:0]    state_dbg
);

  localparam int HW = (RST_HOLD_CYCLES > 1)    ? $clog2(RST_HOLD_CYCLES)    : 1;
  localparam int TW = (LOCK_TIMEOUT > 1)       ? $clog2(LOCK_TIMEOUT)       : 1;
  localparam int SW = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;

  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(LOCK_TIMEOUT - 1);
  localparam logic [SW-1:0] STAB_LAST = SW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);
  localparam logic [7:0]    LOSS_MAX  = 8'hFF;

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [TW-1:0]   tmo_q, tmo_d, tmo_inc;
  logic [SW-1:0]   stab_q, stab_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic [7:0]      loss_q, loss_d;
  logic            sync1_q, sync2_q;
  logic            locked_s;
  logic            do_timeout;
  logic            pll_rst_q, pll_rst_d;
  logic            sys_rst_n_q, sys_rst_n_d;
  logic            ready_q, ready_d;
  logic            fail_q, fail_d;

  assign locked_s = sync2_q;

  // Two-flop synchronizer bringing the asynchronous lock flag into refclk.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pll_locked;
      sync2_q <= sync1_q;
    end
  end

  // Timeout counter advance; it holds at its terminal value instead of wrapping.
  assign tmo_inc = (tmo_q >= TMO_LAST) ? tmo_q : tmo_q + 1'b1;

  // Next-state, counter and registered-output logic of the sequencer.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    tmo_d      = tmo_q;
    stab_d     = stab_q;
    retry_d    = retry_q;
    loss_d     = loss_q;
    do_timeout = 1'b0;

    if (soft_reset) begin
      state_d = S_RESET_PLL;
      hold_d  = '0;
      tmo_d   = '0;
      stab_d  = '0;
      retry_d = '0;
    end else begin
      unique case (state_q)
        S_RESET_PLL: begin
          if (hold_q == HOLD_LAST) begin
            state_d = S_WAIT_LOCK;
            tmo_d   = '0;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end

        S_WAIT_LOCK: begin
          if (locked_s) begin
            state_d = S_STABLE;
            stab_d  = '0;
            tmo_d   = tmo_inc;
          end else if (tmo_q >= TMO_LAST) begin
            do_timeout = 1'b1;
          end else begin
            tmo_d = tmo_inc;
          end
        end

        S_STABLE: begin
          // The attempt budget keeps draining while lock is being qualified.
          tmo_d = tmo_inc;
          if (!locked_s) begin
            // A one-cycle dropout would otherwise bounce straight back into
            // STABLE before WAIT_LOCK could see it, so an exhausted budget is
            // acted on here to make a flapping lock time out.
            if (tmo_q >= TMO_LAST) begin
              do_timeout = 1'b1;
            end else begin
              state_d = S_WAIT_LOCK;
            end
          end else if (stab_q == STAB_LAST) begin
            state_d = S_RUN;
          end else begin
            stab_d = stab_q + 1'b1;
          end
        end

        S_RUN: begin
          if (!locked_s) begin
            loss_d  = (loss_q == LOSS_MAX) ? loss_q : loss_q + 1'b1;
            retry_d = '0;
            hold_d  = '0;
            state_d = S_RESET_PLL;
          end
        end

        S_FAIL: begin
          state_d = S_FAIL;
        end

        default: begin
          state_d = S_RESET_PLL;
          hold_d  = '0;
        end
      endcase

      if (do_timeout) begin
        if (retry_q == RETRY_MAX) begin
          state_d = S_FAIL;
        end else begin
          retry_d = retry_q + 1'b1;
          hold_d  = '0;
          state_d = S_RESET_PLL;
        end
      end
    end

    // Outputs are decoded from the next state so they change with the state.
    pll_rst_d   = (state_d == S_RESET_PLL) || (state_d == S_FAIL);
    sys_rst_n_d = (state_d == S_RUN);
    ready_d     = (state_d == S_RUN);
    fail_d      = (state_d == S_FAIL);
  end

  // State, counter and output registers.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      state_q     <= S_RESET_PLL;
      hold_q      <= '0;
      tmo_q       <= '0;
      stab_q      <= '0;
      retry_q     <= '0;
      loss_q      <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      tmo_q       <= tmo_d;
      stab_q      <= stab_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      pll_rst_q   <= pll_rst_d;
      sys_rst_n_q <= sys_rst_n_d;
      ready_q     <= ready_d;
      fail_q      <= fail_d;
    end
  end

  assign pll_rst       = pll_rst_q;
  assign sys_rst_n     = sys_rst_n_q;
  assign ready         = ready_q;
  assign fail          = fail_q;
  assign retry_cnt     = retry_q;
  assign lock_loss_cnt = loss_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Directed testbench for pll_reset_ctrl with RST_HOLD_CYCLES=4,
// LOCK_TIMEOUT=20, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2. Outputs are sampled
// 1 time unit after each rising edge; "edge k" counts rising edges after
// rst_n is released (or after a soft_reset edge where noted).
module tb_pll_reset_ctrl;

  logic       refclk;
  logic       rst_n;
  logic       pll_locked;
  logic       soft_reset;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic       fail;
  logic [1:0] retry_cnt;
  logic [7:0] lock_loss_cnt;
  logic [2:0] state_dbg;

  int checks;
  int errors;

  pll_reset_ctrl #(
    .RST_HOLD_CYCLES   (4),
    .LOCK_TIMEOUT      (20),
    .LOCK_STABLE_CYCLES(8),
    .MAX_RETRIES       (2)
  ) dut (
    .refclk       (refclk),
    .rst_n        (rst_n),
    .pll_locked   (pll_locked),
    .soft_reset   (soft_reset),
    .pll_rst      (pll_rst),
    .sys_rst_n    (sys_rst_n),
    .ready        (ready),
    .fail         (fail),
    .retry_cnt    (retry_cnt),
    .lock_loss_cnt(lock_loss_cnt),
    .state_dbg    (state_dbg)
  );

  // Clock and watchdog.
  initial begin
    refclk = 1'b0;
    forever #5 refclk = ~refclk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks.
  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic apply_reset();
    rst_n      = 1'b0;
    soft_reset = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    pll_locked = 1'b0;
    apply_reset();
    checks++;
    if (pll_rst !== 1'b1 || sys_rst_n !== 1'b0 || ready !== 1'b0 || fail !== 1'b0 ||
        retry_cnt !== 2'd0 || lock_loss_cnt !== 8'd0 || state_dbg !== 3'd0) begin
      errors++;
      $display("FAIL reset_values: pll_rst=%b sys_rst_n=%b ready=%b fail=%b retry=%0d loss=%0d st=%0d, want 1 0 0 0 0 0 0",
               pll_rst, sys_rst_n, ready, fail, retry_cnt, lock_loss_cnt, state_dbg);
    end
  endtask

  // Scenario 1: clean lock 10 cycles after the PLL reset falls.
  task automatic test_lock();
    pll_locked = 1'b0;
    apply_reset();
    tick_n(3);
    checks++;
    if (pll_rst !== 1'b1) begin
      errors++;
      $display("FAIL lock_hold_edge3: pll_rst=%b want 1", pll_rst);
    end
    tick();
    checks++;
    if (pll_rst !== 1'b0) begin
      errors++;
      $display("FAIL lock_hold_edge4: pll_rst=%b want 0", pll_rst);
    end
    tick_n(10);
    pll_locked = 1'b1;
    tick_n(10);
    checks++;
    if (ready !== 1'b0 || sys_rst_n !== 1'b0) begin
      errors++;
      $display("FAIL lock_early: ready=%b sys_rst_n=%b want 0 0", ready, sys_rst_n);
    end
    tick();
    checks++;
    if (ready !== 1'b1 || sys_rst_n !== 1'b1 || retry_cnt !== 2'd0 || fail !== 1'b0) begin
      errors++;
      $display("FAIL lock_release: ready=%b sys_rst_n=%b retry=%0d fail=%b want 1 1 0 0",
               ready, sys_rst_n, retry_cnt, fail);
    end
  endtask

  // Scenario 2: PLL never locks; three attempts then FAIL at edge 72.
  task automatic test_timeout_fail();
    logic       exp_rst;
    logic [1:0] exp_retry;
    logic       exp_fail;
    pll_locked = 1'b0;
    apply_reset();
    for (int k = 1; k <= 80; k++) begin
      tick();
      exp_rst   = (k >= 72) ? 1'b1 : ((k % 24) < 4);
      exp_retry = (k >= 72) ? 2'd2 : 2'(k / 24);
      exp_fail  = (k >= 72);
      checks++;
      if (pll_rst !== exp_rst || retry_cnt !== exp_retry || fail !== exp_fail) begin
        errors++;
        $display("FAIL timeout_seq edge %0d: pll_rst=%b retry=%0d fail=%b want %b %0d %b",
                 k, pll_rst, retry_cnt, fail, exp_rst, exp_retry, exp_fail);
      end
    end
  endtask

  // Scenario 5: soft_reset out of FAIL, then a normal lock.
  task automatic test_soft_fail();
    soft_reset = 1'b1;
    tick();
    soft_reset = 1'b0;
    checks++;
    if (fail !== 1'b0 || retry_cnt !== 2'd0 || pll_rst !== 1'b1) begin
      errors++;
      $display("FAIL soft_fail_exit: fail=%b retry=%0d pll_rst=%b want 0 0 1", fail, retry_cnt, pll_rst);
    end
    tick_n(3);
    checks++;
    if (pll_rst !== 1'b1) begin
      errors++;
      $display("FAIL soft_fail_hold: pll_rst=%b want 1", pll_rst);
    end
    tick();
    checks++;
    if (pll_rst !== 1'b0) begin
      errors++;
      $display("FAIL soft_fail_fall: pll_rst=%b want 0", pll_rst);
    end
    pll_locked = 1'b1;
    tick_n(10);
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL soft_fail_early: ready=%b want 0", ready);
    end
    tick();
    checks++;
    if (ready !== 1'b1 || sys_rst_n !== 1'b1 || fail !== 1'b0) begin
      errors++;
      $display("FAIL soft_fail_relock: ready=%b sys_rst_n=%b fail=%b want 1 1 0", ready, sys_rst_n, fail);
    end
  endtask

  // Scenario 3: lock glitch during qualification, then a flapping lock.
  task automatic test_flap();
    logic found;
    logic saw_ready;
    pll_locked = 1'b0;
    apply_reset();
    tick_n(6);
    pll_locked = 1'b1;
    tick_n(5);
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    saw_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ready !== 1'b0) saw_ready = 1'b1;
    end
    checks++;
    if (saw_ready !== 1'b0) begin
      errors++;
      $display("FAIL glitch_early: ready seen=%b want 0", saw_ready);
    end
    tick();
    checks++;
    if (ready !== 1'b1 || lock_loss_cnt !== 8'd0) begin
      errors++;
      $display("FAIL glitch_release: ready=%b loss=%0d want 1 0", ready, lock_loss_cnt);
    end

    pll_locked = 1'b0;
    apply_reset();
    tick_n(4);
    found = 1'b0;
    saw_ready = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      pll_locked = ((i % 6) != 5);
      tick();
      if (ready !== 1'b0) saw_ready = 1'b1;
      if (retry_cnt === 2'd1) found = 1'b1;
    end
    pll_locked = 1'b0;
    checks++;
    if (found !== 1'b1 || pll_rst !== 1'b1 || saw_ready !== 1'b0) begin
      errors++;
      $display("FAIL flap_timeout: retry_step=%b pll_rst=%b ready_seen=%b want 1 1 0",
               found, pll_rst, saw_ready);
    end
  endtask

  // Soft reset inside RESET_PLL restarts the hold count.
  task automatic test_soft_hold();
    pll_locked = 1'b0;
    apply_reset();
    tick_n(2);
    soft_reset = 1'b1;
    tick();
    soft_reset = 1'b0;
    tick_n(3);
    checks++;
    if (pll_rst !== 1'b1) begin
      errors++;
      $display("FAIL soft_hold_restart: pll_rst=%b want 1", pll_rst);
    end
    tick();
    checks++;
    if (pll_rst !== 1'b0) begin
      errors++;
      $display("FAIL soft_hold_fall: pll_rst=%b want 0", pll_rst);
    end
  endtask

  // Scenario 4: lock loss in RUN, relock, and saturation of the loss counter.
  task automatic test_lock_loss();
    int   n;
    logic stuck;
    pll_locked = 1'b0;
    apply_reset();
    tick_n(30);
    pll_locked = 1'b1;
    n = 0;
    while (ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (ready !== 1'b1 || retry_cnt !== 2'd1) begin
      errors++;
      $display("FAIL loss_prelock: ready=%b retry=%0d want 1 1", ready, retry_cnt);
    end
    pll_locked = 1'b0;
    tick_n(2);
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL loss_edge2: ready=%b want 1", ready);
    end
    tick();
    checks++;
    if (ready !== 1'b0 || sys_rst_n !== 1'b0 || pll_rst !== 1'b1 ||
        lock_loss_cnt !== 8'd1 || retry_cnt !== 2'd0) begin
      errors++;
      $display("FAIL loss_edge3: ready=%b sys_rst_n=%b pll_rst=%b loss=%0d retry=%0d want 0 0 1 1 0",
               ready, sys_rst_n, pll_rst, lock_loss_cnt, retry_cnt);
    end
    pll_locked = 1'b1;
    n = 0;
    while (ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL loss_relock: ready=%b want 1", ready);
    end

    stuck = 1'b0;
    for (int i = 0; i < 299; i++) begin
      pll_locked = 1'b0;
      n = 0;
      while (ready !== 1'b0 && n < 10) begin
        tick();
        n++;
      end
      if (ready !== 1'b0) stuck = 1'b1;
      pll_locked = 1'b1;
      n = 0;
      while (ready !== 1'b1 && n < 40) begin
        tick();
        n++;
      end
      if (ready !== 1'b1) stuck = 1'b1;
      if (i == 253) begin
        checks++;
        if (lock_loss_cnt !== 8'd255) begin
          errors++;
          $display("FAIL loss_at_255: loss=%0d want 255", lock_loss_cnt);
        end
      end
    end
    checks++;
    if (lock_loss_cnt !== 8'd255 || stuck !== 1'b0) begin
      errors++;
      $display("FAIL loss_saturate: loss=%0d stuck=%b want 255 0", lock_loss_cnt, stuck);
    end
  endtask

  // Scenario 6: rst_n together with soft_reset in the middle of WAIT_LOCK.
  task automatic test_reset_mid_wait();
    pll_locked = 1'b0;
    tick_n(3);
    tick_n(4);
    tick_n(3);
    checks++;
    if (pll_rst !== 1'b0 || state_dbg !== 3'd1 || lock_loss_cnt === 8'd0) begin
      errors++;
      $display("FAIL mid_wait_setup: pll_rst=%b st=%0d loss=%0d want 0 1 nonzero",
               pll_rst, state_dbg, lock_loss_cnt);
    end
    rst_n      = 1'b0;
    soft_reset = 1'b1;
    tick();
    checks++;
    if (pll_rst !== 1'b1 || sys_rst_n !== 1'b0 || ready !== 1'b0 || fail !== 1'b0 ||
        retry_cnt !== 2'd0 || lock_loss_cnt !== 8'd0 || state_dbg !== 3'd0) begin
      errors++;
      $display("FAIL mid_wait_reset: pll_rst=%b sys_rst_n=%b ready=%b fail=%b retry=%0d loss=%0d st=%0d want 1 0 0 0 0 0 0",
               pll_rst, sys_rst_n, ready, fail, retry_cnt, lock_loss_cnt, state_dbg);
    end
    soft_reset = 1'b0;
    rst_n      = 1'b1;
    tick_n(4);
    checks++;
    if (pll_rst !== 1'b0) begin
      errors++;
      $display("FAIL mid_wait_restart: pll_rst=%b want 0", pll_rst);
    end
  endtask

  // Test sequence and final report.
  initial begin
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    pll_locked = 1'b0;
    soft_reset = 1'b0;
    test_reset();
    test_lock();
    test_timeout_fail();
    test_soft_fail();
    test_flap();
    test_soft_hold();
    test_lock_loss();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pll_reset_ctrl.md
# pll_reset_ctrl

Reset sequencer and lock supervisor for the fabric PLL. It drives the PLL reset, waits for lock with a bounded timeout, and retries a fixed number of times. It qualifies lock stability, then releases the downstream system reset; on loss of lock it re-sequences. It sits between board reset and the PLL wrapper and runs entirely on the free-running reference clock.

## Interface
Parameters:
- RST_HOLD_CYCLES, 16: cycles `pll_rst` is held high per attempt (≥1)
- LOCK_TIMEOUT, 50000: maximum cycles spent waiting for lock per attempt (≥1); 1 ms at 50 MHz
- LOCK_STABLE_CYCLES, 256: consecutive synchronized-lock cycles required before release (≥1)
- MAX_RETRIES, 3: additional attempts after the first timeout (≥0)

Ports:
- `refclk`  in  1  reference clock, free-running; the only clock
- `rst_n`  in  1  synchronous, active-low reset
- `pll_locked`  in  1  PLL lock flag; asynchronous, so it passes through a 2-FF synchronizer to give `locked_s`
- `soft_reset`  in  1  single-cycle request to re-sequence the PLL
- `pll_rst`  out  1  PLL reset, active-high
- `sys_rst_n`  out  1  downstream reset, active-low
- `ready`  out  1  PLL qualified and system released
- `fail`  out  1  retries exhausted
- `retry_cnt`  out  $clog2(MAX_RETRIES+1)  timeouts in the current sequence
- `lock_loss_cnt`  out  8  lock losses seen in RUN; saturates at 255

## Operation
- All outputs are registered and updated on the same edge as the state.
- Reset values while `rst_n`=0: state RESET_PLL, all counters 0, `pll_rst`=1, `sys_rst_n`=0, `ready`=0, `fail`=0, `retry_cnt`=0, `lock_loss_cnt`=0. Synchronizer flops are cleared to 0.
- Priority: `rst_n` > `soft_reset` > lock/timeout events.
- States:
  - RESET_PLL: `pll_rst`=1. Stays here exactly RST_HOLD_CYCLES cycles, then goes to WAIT_LOCK with the timeout counter cleared.
  - WAIT_LOCK: `pll_rst`=0.
    - If `locked_s`=1, go to STABLE with the stable counter cleared.
    - Otherwise, if the timeout counter ≥ LOCK_TIMEOUT-1:
      - if `retry_cnt`==MAX_RETRIES, go to FAIL;
      - else increment `retry_cnt` and go to RESET_PLL.
  - STABLE: the timeout counter keeps running and saturates; it is not cleared.
    - If `locked_s`=0, go back to WAIT_LOCK. A flapping lock therefore still times out.
    - After LOCK_STABLE_CYCLES consecutive cycles with `locked_s`=1, go to RUN.
  - RUN: `sys_rst_n`=1, `ready`=1.
    - If `locked_s`=0, increment `lock_loss_cnt` (saturating), clear `retry_cnt`, and go to RESET_PLL.
  - FAIL: `pll_rst`=1, `sys_rst_n`=0, `fail`=1. Only `rst_n` or `soft_reset` leave this state.
- In every state except RUN, `sys_rst_n`=0 and `ready`=0.
- `soft_reset` in any state: go to RESET_PLL, clear the hold, timeout and stable counters, clear `retry_cnt` and `fail`. `lock_loss_cnt` is unchanged.
- A `soft_reset` during RESET_PLL restarts the hold count.
- Counter widths come from `$clog2` of their respective parameters. No counter wraps; each saturates at its terminal value.

## Timing
Latencies below assume `pll_locked` is driven synchronously to `refclk`:
- `pll_rst` first falls RST_HOLD_CYCLES edges after the first edge with `rst_n`=1.
- `pll_locked` rising to `ready`/`sys_rst_n` rising: LOCK_STABLE_CYCLES+3 edges (2 synchronizer, 1 detect, N stable).
- `pll_locked` falling in RUN to `ready`=0, `sys_rst_n`=0 and `pll_rst`=1: 3 edges.
- Each failed attempt costs RST_HOLD_CYCLES+LOCK_TIMEOUT cycles.
- `fail` asserts (MAX_RETRIES+1)·(RST_HOLD_CYCLES+LOCK_TIMEOUT) edges after `rst_n` release when the PLL never locks.
- `rst_n`=0 in any state: reset values on the next edge.
- `soft_reset`: effect is visible on the next edge.

## Test plan
All scenarios use RST_HOLD_CYCLES=4, LOCK_TIMEOUT=20, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2.
1. Release `rst_n`; raise `pll_locked` 10 cycles after `pll_rst` falls -> `pll_rst` high exactly 4 cycles; `ready`/`sys_rst_n` rise 11 edges after `pll_locked`; `retry_cnt`=0, `fail`=0.
2. Hold `pll_locked`=0 -> three 4-cycle `pll_rst` pulses separated by 20-cycle waits; `retry_cnt` steps 0,1,2; `fail`=1 at edge 72 after release; `pll_rst` then stays 1.
3. In STABLE, raise `pll_locked` for 5 cycles, drop it for 1, then hold it high -> no release after the first 5 cycles; `ready` rises 11 edges after the final rise; `lock_loss_cnt`=0. Repeat with 1-cycle drops every 6 cycles -> times out and `retry_cnt` increments.
4. In RUN, drop `pll_locked` -> 3 edges later `ready`=0, `sys_rst_n`=0, `pll_rst`=1, `lock_loss_cnt`=1, `retry_cnt`=0. Relock -> `ready` returns. Force 300 losses -> `lock_loss_cnt` holds at 255.
5. Pulse `soft_reset` in FAIL -> next edge `fail`=0, `retry_cnt`=0, `pll_rst`=1 for 4 cycles, then a normal lock sequence.
6. Assert `rst_n`=0 mid-WAIT_LOCK, with `rst_n` and `soft_reset` asserted together -> every output takes its reset value on the next edge and `lock_loss_cnt` clears.
